// File: rtl/tt_um_unload.sv
// Weight readback: snapshots the ternary weight array and streams it out in chunks over valid/ready.
// Optional UNLOAD_CHECKSUM_EN appends a final beat carrying the XOR of all data chunks.
module tt_um_unload #(
    parameter int MAX_IN_LEN  = 14,
    parameter int MAX_OUT_LEN = 7,
    parameter int WIDTH       = 2,
    parameter int NUM_CHUNKS  = (WIDTH * MAX_IN_LEN * MAX_OUT_LEN) / MAX_IN_LEN,
    parameter int CNT_BITS    = $clog2(NUM_CHUNKS + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     abort,
    input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0]  weights_in,
    input  logic                                     out_ready,
    output logic [MAX_IN_LEN-1:0]                    out_data,
    output logic                                     out_valid,
    output logic                                     out_last,
    output logic                                     busy,
    output logic [CNT_BITS-1:0]                      beat_idx,
    output logic                                     done
);

    localparam int TOTAL_BITS = WIDTH * MAX_IN_LEN * MAX_OUT_LEN;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

`ifdef UNLOAD_CHECKSUM_EN
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(NUM_CHUNKS);
`else
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(NUM_CHUNKS - 1);
`endif

    logic [0:0]            state_q, state_d;
    logic [TOTAL_BITS-1:0] snap_q, snap_d;
    logic [CNT_BITS-1:0]   beat_q, beat_d;
    logic                  done_q, done_d;
    logic                  sending;
    logic                  at_last;

`ifdef UNLOAD_CHECKSUM_EN
    logic [MAX_IN_LEN-1:0] acc_q, acc_d;
`endif

    assign sending = (state_q == S_SEND);
    assign at_last = (beat_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
`ifdef UNLOAD_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    snap_d  = weights_in;
                    beat_d  = '0;
                    state_d = S_SEND;
`ifdef UNLOAD_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            S_SEND: begin
                // abort takes priority over a transfer in the same cycle
                if (abort) begin
                    state_d = S_IDLE;
                    beat_d  = '0;
`ifdef UNLOAD_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end else if (out_ready) begin
                    snap_d = snap_q >> MAX_IN_LEN;
                    beat_d = beat_q + CNT_BITS'(1);
`ifdef UNLOAD_CHECKSUM_EN
                    // snapshot is fully drained by the checksum beat, so XOR there adds zero
                    acc_d  = acc_q ^ snap_q[MAX_IN_LEN-1:0];
`endif
                    if (at_last) begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

`ifdef UNLOAD_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    always_comb begin
        out_data = '0;
        if (sending) begin
`ifdef UNLOAD_CHECKSUM_EN
            out_data = (beat_q == CNT_BITS'(NUM_CHUNKS)) ? acc_q : snap_q[MAX_IN_LEN-1:0];
`else
            out_data = snap_q[MAX_IN_LEN-1:0];
`endif
        end
    end

    assign out_valid = sending;
    assign busy      = sending;
    assign out_last  = sending && at_last;
    assign beat_idx  = beat_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tt_um_unload.sv
// Scoreboard bench for tt_um_unload: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_tt_um_unload;

    localparam int CH = 14;
    localparam int NC = 14;
    localparam int TW = 196;
`ifdef UNLOAD_CHECKSUM_EN
    localparam int NB = NC + 1;
`else
    localparam int NB = NC;
`endif

    typedef struct {
        logic [CH-1:0] data;
        logic          last;
        logic [3:0]    idx;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [TW-1:0] weights_in = '0;
    logic          out_ready = 1'b0;
    logic [CH-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic [3:0]    beat_idx;
    logic          done;

    beat_t exp_q[$];
    int    n_pass = 0;
    int    n_total = 0;

    logic          pend = 1'b0;
    logic          stall = 1'b0;
    logic [CH-1:0] s_data;
    logic          s_last;
    logic [3:0]    s_idx;

    tt_um_unload dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .weights_in(weights_in), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .busy(busy), .beat_idx(beat_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [TW-1:0] ramp();
        logic [TW-1:0] w;
        w = '0;
        for (int k = 0; k < NC; k++) w[k*CH +: CH] = CH'(k + 1);
        return w;
    endfunction

    // Monitor: a beat transfers at the next posedge when valid && ready && !abort.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            pend  = 1'b0;
            stall = 1'b0;
        end else begin
            if (pend || done) check(done == pend, "done_pulse", 32'(done), 32'(pend));
            pend = 1'b0;
            if (stall)
                check(out_valid && out_data == s_data && out_last == s_last && beat_idx == s_idx,
                      "hold_stable", {out_valid, out_last, beat_idx, out_data}, {1'b1, s_last, s_idx, s_data});
            stall  = out_valid && !out_ready && !abort;
            s_data = out_data;
            s_last = out_last;
            s_idx  = beat_idx;
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_beat", 32'(out_data), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check(out_data == e.data && out_last == e.last && beat_idx == e.idx, "beat",
                          {out_last, beat_idx, out_data}, {e.last, e.idx, e.data});
                    if (e.last) pend = 1'b1;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the start edge.
    task automatic start_frame(input logic [TW-1:0] w);
        beat_t b;
        logic [CH-1:0] acc;
        acc = '0;
        for (int k = 0; k < NC; k++) begin
            b.data = w[k*CH +: CH];
            b.idx  = 4'(k);
            b.last = (k == NB - 1);
            acc    = acc ^ b.data;
            exp_q.push_back(b);
        end
`ifdef UNLOAD_CHECKSUM_EN
        b.data = acc;
        b.idx  = 4'(NC);
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
        weights_in = w;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check(exp_q.size() == 0, "drain_timeout", 32'(exp_q.size()), 32'h0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (!done && i < 60) begin
            @(posedge clk); #1;
            i++;
        end
        check(done == 1'b1, "wait_done_timeout", 32'(done), 32'h1);
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1001;

        // Reset then idle
        rst = 1'b1;
        #12 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check({out_valid, out_last, busy, done, beat_idx, out_data} == '0, "reset_idle",
                  {out_valid, out_last, busy, done, beat_idx, out_data}, 32'h0);
        end

        // Full frame at full throughput
        out_ready = 1'b1;
        start_frame(ramp());
        check(out_valid && busy && beat_idx == 4'd0 && out_data == 14'd1, "first_valid_after_start",
              {out_valid, busy, beat_idx, out_data}, {1'b1, 1'b1, 4'd0, 14'd1});
        repeat (NB) @(posedge clk);
        #1;
        check(exp_q.size() == 0 && done, "frame_in_NB_cycles", {28'(exp_q.size()), 3'b0, done}, 32'h1);
        drain();

        // Backpressure
        start_frame(ramp());
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            out_ready = pat[3 - (i % 4)];
            @(posedge clk); #1;
        end
        check(exp_q.size() == 0, "backpressure_timeout", 32'(exp_q.size()), 32'h0);
        out_ready = 1'b1;
        drain();

        // Snapshot isolation, start while busy, back-to-back start in done cycle
        start_frame(ramp());
        repeat (5) @(posedge clk);
        #1;
        check(beat_idx == 4'd5, "isolation_beat5", 32'(beat_idx), 32'd5);
        weights_in = '1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        start_frame('1);
        check(out_valid && out_data == 14'h3FFF && beat_idx == 4'd0, "b2b_first_beat",
              {out_valid, beat_idx, out_data}, {1'b1, 4'd0, 14'h3FFF});
        drain();

        // Abort at beat 7, then replay
        start_frame(ramp());
        repeat (7) @(posedge clk);
        #1;
        check(beat_idx == 4'd7, "abort_at_beat7", 32'(beat_idx), 32'd7);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        check(!out_valid && !out_last && beat_idx == 4'd0 && !busy, "after_abort",
              {out_valid, out_last, busy, beat_idx}, 32'h0);
        @(posedge clk); #1;
        check(done == 1'b0, "no_done_after_abort", 32'(done), 32'h0);
        start_frame(ramp());
        drain();

        // Asynchronous reset mid-frame
        start_frame(ramp());
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check({out_valid, out_last, busy, done, beat_idx, out_data} == '0, "async_reset_mid_frame",
              {out_valid, out_last, busy, done, beat_idx, out_data}, 32'h0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check(!out_valid && !done, "post_reset_idle", {out_valid, done}, 32'h0);
        start_frame(ramp());
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
